// File: rtl/osd_dem_uart_pkg.sv
// Shared definitions for the DEM UART character arbiter: line-feed release
// character and arbiter state encoding.
package osd_dem_uart_pkg;

  localparam logic [7:0] CHAR_LF = 8'h0A;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/osd_dem_uart_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping around, among N requesters.
module osd_rr_pick
  import osd_dem_uart_pkg::*;
#(
  parameter int N    = 2,
  parameter int SRCW = 1
) (
  input  logic [N-1:0]    req,
  input  logic [SRCW-1:0] ptr,
  output logic            valid,
  output logic [SRCW-1:0] index
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int             off;
  int             sum;

  // Rotate so that bit 0 of rot corresponds to the requester at ptr.
  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[N-1:0];
    valid = 1'b0;
    off   = 0;
    for (int k = 0; k < N; k++) begin
      if (!valid && rot[k]) begin
        valid = 1'b1;
        off   = k;
      end
    end
    sum = int'(ptr) + off;
    if (sum >= N) begin
      sum = sum - N;
    end
    index = SRCW'(sum);
  end

endmodule

// File: rtl/osd_dem_uart_arb.sv
// Merges N 16550 front-end character streams into one, granting one source
// at a time until line feed, burst limit or owner idle timeout.
module osd_dem_uart_arb
  import osd_dem_uart_pkg::*;
#(
  parameter int  N            = 2,
  parameter int  MAX_BURST    = 64,
  parameter int  IDLE_TIMEOUT = 16,
  localparam int SRCW         = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      in_valid,
  input  logic [N*8-1:0]    in_char,
  output logic [N-1:0]      in_ready,
  input  logic              drop,
  output logic              out_valid,
  output logic [7:0]        out_char,
  output logic [SRCW-1:0]   out_src,
  input  logic              out_ready,
  output logic              busy
);

  localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);
  localparam logic [7:0] IDLE_LIM  = 8'(IDLE_TIMEOUT);

  arb_state_e      state_q, state_d;
  logic [SRCW-1:0] owner_q, owner_d;
  logic [SRCW-1:0] rr_q, rr_d;
  logic [7:0]      burst_q, burst_d;
  logic [7:0]      idle_q, idle_d;

  logic [7:0]      chars [N];
  logic            own_valid;
  logic [7:0]      own_char;
  logic [SRCW-1:0] next_ptr;
  logic            pick_valid;
  logic [SRCW-1:0] pick_idx;
  logic            xfer;
  logic            rel;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      chars[i] = in_char[8*i +: 8];
    end
  end

  assign own_valid = in_valid[owner_q];
  assign own_char  = chars[owner_q];
  assign next_ptr  = (int'(owner_q) == N - 1) ? '0 : owner_q + 1'b1;

  osd_rr_pick #(
    .N    (N),
    .SRCW (SRCW)
  ) u_pick (
    .req   (in_valid),
    .ptr   (rr_q),
    .valid (pick_valid),
    .index (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    burst_d   = burst_q;
    idle_d    = idle_q;
    out_valid = 1'b0;
    out_char  = '0;
    out_src   = '0;
    in_ready  = '0;
    xfer      = 1'b0;
    rel       = 1'b0;
    if (drop) begin
      // Swallow everything while the DEM is not activated; keep rr fairness.
      in_ready = '1;
      state_d  = ST_IDLE;
      burst_d  = '0;
      idle_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            owner_d = pick_idx;
            state_d = ST_GRANT;
          end
        end
        ST_GRANT: begin
          out_valid         = own_valid;
          out_char          = own_char;
          out_src           = owner_q;
          in_ready[owner_q] = out_ready;
          xfer              = own_valid & out_ready;
          burst_d           = burst_q + {7'd0, xfer};
          idle_d            = own_valid ? 8'd0 : idle_q + 8'd1;
          rel = (xfer && (own_char == CHAR_LF || burst_d == BURST_LIM)) ||
                (!own_valid && idle_d == IDLE_LIM);
          if (rel) begin
            state_d = ST_IDLE;
            rr_d    = next_ptr;
            burst_d = '0;
            idle_d  = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // A grant interrupted by reset must not complete a handshake.
    if (rst) begin
      in_ready  = '0;
      out_valid = 1'b0;
      out_char  = '0;
      out_src   = '0;
    end
  end

  assign busy = (state_q == ST_GRANT) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      burst_q <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      burst_q <= burst_d;
      idle_q  <= idle_d;
    end
  end

endmodule

// File: tb/tb_osd_dem_uart_arb.sv
// Directed bench for osd_dem_uart_arb with N=2, MAX_BURST=4, IDLE_TIMEOUT=16.
module tb_osd_dem_uart_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  in_valid;
  logic [7:0]  c0, c1;
  logic [15:0] in_char;
  logic [1:0]  in_ready;
  logic        drop;
  logic        out_valid;
  logic [7:0]  out_char;
  logic [0:0]  out_src;
  logic        out_ready;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int n;
  int errs;

  assign in_char = {c1, c0};

  always #5 clk = ~clk;

  osd_dem_uart_arb #(
    .N            (2),
    .MAX_BURST    (4),
    .IDLE_TIMEOUT (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_char   (in_char),
    .in_ready  (in_ready),
    .drop      (drop),
    .out_valid (out_valid),
    .out_char  (out_char),
    .out_src   (out_src),
    .out_ready (out_ready),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 2'b11; c0 = 8'h61; c1 = 8'h31; out_ready = 1'b1; drop = 1'b0;

    // reset: outputs quiet even with sources requesting
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_char", out_char, 0);
    chk("rst_out_src", out_src, 0);
    nxt(); rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_in_ready", in_ready, 0);

    // "ab\n" from src0 while src1 waits
    nxt();
    @(negedge clk);
    chk("a_busy", busy, 1);
    chk("a_char", out_char, 8'h61);
    chk("a_src", out_src, 0);
    chk("a_in_ready", in_ready, 2'b01);
    nxt(); c0 = 8'h62;
    @(negedge clk);
    chk("b_char", out_char, 8'h62);
    nxt(); c0 = 8'h0A;
    @(negedge clk);
    chk("lf_char", out_char, 8'h0A);
    chk("lf_valid", out_valid, 1);
    nxt(); in_valid = 2'b10;
    @(negedge clk);
    chk("gap_busy", busy, 0);
    chk("gap_out_valid", out_valid, 0);
    nxt();
    @(negedge clk);
    chk("src1_busy", busy, 1);
    chk("src1_src", out_src, 1);
    chk("src1_char", out_char, 8'h31);
    chk("src1_in_ready", in_ready, 2'b10);
    nxt(); c1 = 8'h0A;
    @(negedge clk);
    chk("src1_lf", out_char, 8'h0A);
    nxt(); in_valid = 2'b11; c0 = 8'h41; c1 = 8'h31;
    @(negedge clk);
    chk("rr_after_src1", dut.rr_q, 0);
    chk("idle_after_src1", busy, 0);
    nxt();

    // burst limit: src0 streams, released after 4 chars
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("burst0_src", out_src, 0);
      chk("burst0_char", out_char, 32'h41 + k);
      nxt(); c0 = c0 + 8'd1;
    end
    @(negedge clk);
    chk("burst0_release", busy, 0);
    chk("burst0_rr", dut.rr_q, 1);
    nxt();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("burst1_src", out_src, 1);
      chk("burst1_char", out_char, 8'h31);
      nxt();
    end
    in_valid = 2'b00;
    @(negedge clk);
    chk("burst1_release", busy, 0);
    chk("burst1_rr", dut.rr_q, 0);

    // idle timeout: one char then silence
    nxt(); in_valid = 2'b01; c0 = 8'h5A;
    nxt();
    @(negedge clk);
    chk("to_char", out_char, 8'h5A);
    chk("to_valid", out_valid, 1);
    nxt(); in_valid = 2'b00;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      nxt();
    end
    chk("timeout_cycles", n, 16);

    // back-pressure for 100 cycles never releases
    nxt(); in_valid = 2'b01; out_ready = 1'b0; c0 = 8'h51;
    nxt();
    errs = 0;
    repeat (100) begin
      @(negedge clk);
      if (!busy || in_ready != 2'b00 || !out_valid || dut.idle_q != 8'd0) errs++;
      nxt();
    end
    chk("bp_errs", errs, 0);
    @(negedge clk);
    chk("bp_burst", dut.burst_q, 0);
    chk("bp_busy", busy, 1);

    // drop mid-burst
    nxt(); out_ready = 1'b1; c0 = 8'h61;
    @(negedge clk);
    chk("pre_drop_char", out_char, 8'h61);
    nxt(); drop = 1'b1; in_valid = 2'b11; c0 = 8'hEE;
    @(negedge clk);
    chk("drop_out_valid", out_valid, 0);
    chk("drop_in_ready", in_ready, 2'b11);
    chk("drop_out_char", out_char, 0);
    nxt();
    @(negedge clk);
    chk("drop_busy", busy, 0);
    chk("drop_in_ready2", in_ready, 2'b11);
    nxt(); drop = 1'b0; c0 = 8'h61;
    @(negedge clk);
    chk("undrop_busy", busy, 0);
    chk("undrop_in_ready", in_ready, 2'b00);
    chk("undrop_rr", dut.rr_q, 1);
    nxt();
    @(negedge clk);
    chk("undrop_src", out_src, 1);
    chk("undrop_grant", busy, 1);

    // LF as the 4th char: exactly one release
    nxt(); c1 = 8'h32;
    @(negedge clk);
    chk("lfb_2", out_char, 8'h32);
    nxt(); c1 = 8'h33;
    @(negedge clk);
    chk("lfb_3", out_char, 8'h33);
    nxt(); c1 = 8'h0A;
    @(negedge clk);
    chk("lfb_4", out_char, 8'h0A);
    nxt();
    @(negedge clk);
    chk("lfb_busy", busy, 0);
    chk("lfb_rr", dut.rr_q, 0);
    chk("lfb_burst", dut.burst_q, 0);
    nxt();
    @(negedge clk);
    chk("lfb_next_src", out_src, 0);
    chk("lfb_next_busy", busy, 1);

    // reset mid-burst abandons the grant
    nxt(); rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_char", out_char, 0);
    nxt(); rst = 1'b0;
    @(negedge clk);
    chk("after_rst_busy", busy, 0);
    chk("after_rst_out_valid", out_valid, 0);
    chk("after_rst_in_ready", in_ready, 0);
    nxt();
    @(negedge clk);
    chk("after_rst_grant", busy, 1);
    chk("after_rst_src", out_src, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
